// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM state encoding
// and the mask of high-byte bits that must be zero in a well-formed stream.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_INS_LO = 3'd2,
    S_INS_HI = 3'd3,
    S_START  = 3'd4,
    S_RUN    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Only bit 0 of an instruction high byte carries payload (instr[8]).
  localparam logic [7:0] HI_RESV_MASK = 8'hFE;

endpackage

// File: rtl/inst_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes 9-bit instructions
// into instruction memory, pulses core_start, then times the core until halt.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 9,
  parameter int DEPTH     = 1024,
  parameter int START_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               core_start,
  input  logic               core_halt,
  output logic               done,
  output logic               err,
  output logic [31:0]        cycles
);

  localparam int SW = $clog2(START_CYC + 2);

  // Handshake: a byte transfers on a rising clk edge where in_valid and
  // in_ready are both high; in_ready depends only on registered state.
  state_t            state, state_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       count;
  logic [7:0]        ins_lo;
  logic [ADDR_W-1:0] addr;
  logic [SW-1:0]     start_cnt;

  logic        accept;
  logic [15:0] count_in;
  logic        hi_bad;
  logic        last_pair;
  logic        write_fire;
  logic        start_on;

  assign accept    = in_valid && in_ready;
  assign count_in  = {in_data, len_lo};
  assign hi_bad    = |(in_data & HI_RESV_MASK);
  assign last_pair = (17'(addr) + 17'd1) == 17'(count);

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN_LO;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (17'(count_in) > 17'(DEPTH)) state_nxt = S_ERR;
          else if (count_in == 16'd0)     state_nxt = S_START;
          else                            state_nxt = S_INS_LO;
        end
      end
      S_INS_LO: if (accept) state_nxt = S_INS_HI;
      S_INS_HI: begin
        if (accept) begin
          if (hi_bad)         state_nxt = S_ERR;
          else if (last_pair) state_nxt = S_START;
          else                state_nxt = S_INS_LO;
        end
      end
      S_START: if (start_cnt == SW'(START_CYC)) state_nxt = S_RUN;
      S_RUN:   if (core_halt) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    write_fire = 1'b0;
    start_on   = 1'b0;
    done       = (state == S_DONE);
    err        = (state == S_ERR);
    case (state)
      S_LEN_LO, S_LEN_HI, S_INS_LO: in_ready = !reset;
      S_INS_HI: begin
        in_ready   = !reset;
        write_fire = accept && !hi_bad;
      end
      S_START: start_on = (start_cnt != SW'(START_CYC));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo     <= '0;
      count      <= '0;
      ins_lo     <= '0;
      addr       <= '0;
      start_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_start <= 1'b0;
      cycles     <= '0;
    end else begin
      if (state == S_LEN_LO && accept) len_lo <= in_data;
      if (state == S_LEN_HI && accept) count  <= count_in;
      if (state == S_INS_LO && accept) ins_lo <= in_data;
      wr_en <= write_fire;
      if (write_fire) begin
        wr_addr <= addr;
        wr_data <= INSTR_W'({in_data[0], ins_lo});
        addr    <= addr + 1'b1;
      end
      // core_start is registered so it trails the entry into S_START by one cycle.
      start_cnt  <= (state == S_START) ? start_cnt + 1'b1 : '0;
      core_start <= start_on;
      if (state == S_RUN && !core_halt && cycles != 32'hFFFF_FFFF)
        cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: streams hand-built programs, checks the
// write port, start pulse, halt handling, error paths and mid-load reset.
module tb_inst_loader;

  localparam int ADDR_W    = 16;
  localparam int INSTR_W   = 9;
  localparam int START_CYC = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               core_start;
  logic               core_halt;
  logic               done;
  logic               err;
  logic [31:0]        cycles;

  inst_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(1024), .START_CYC(START_CYC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .core_start(core_start),
    .core_halt(core_halt), .done(done), .err(err), .cycles(cycles)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: expected writes {addr, data} and the cycle each must appear in
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];
  int                        exp_cyc_q[$];
  logic [ADDR_W+INSTR_W-1:0] got_q[$];
  int                        got_cyc_q[$];
  int                        start_count;
  int                        start_first;

  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back({wr_addr, wr_data});
      got_cyc_q.push_back(cyc);
    end
    if (core_start) begin
      if (start_count == 0) start_first = cyc;
      start_count++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_cyc_q.delete(); got_q.delete(); got_cyc_q.delete();
    start_count = 0;
    start_first = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; core_halt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_sb();
  endtask

  // driver: offer one byte after `gap` idle cycles; t = cycle it was accepted in
  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    int waited;
    t = -1;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [8:0] ins, input int gap, input int a, output int t);
    int tl;
    send_byte(ins[7:0], gap, tl);
    send_byte({7'd0, ins[8]}, gap, t);
    exp_q.push_back({a[ADDR_W-1:0], ins});
    exp_cyc_q.push_back(t + 1);
  endtask

  task automatic send_count(input logic [15:0] n, input int gap, output int t);
    int tl;
    send_byte(n[7:0], gap, tl);
    send_byte(n[15:8], gap, t);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_wr_val"}, 64'(got_q[i]), 64'(exp_q[i]));
      check({tag, "_wr_cyc"}, 64'(got_cyc_q[i]), 64'(exp_cyc_q[i]));
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // halt after `prior` counted S_RUN cycles; t = cycle the final byte was accepted
  task automatic halt_after(input string tag, input int t, input int prior);
    wait_until(t + 2 + START_CYC + prior);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cycles"}, 64'(cycles), 64'(prior));
    repeat (2) @(negedge clk);
    check({tag, "_cycles_frozen"}, 64'(cycles), 64'(prior));
  endtask

  int t;
  logic [8:0] prog3[3] = '{9'h1A5, 9'h0FF, 9'h100};
  logic [8:0] prog4[4] = '{9'h001, 9'h1FE, 9'h080, 9'h155};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; core_halt = 1'b0;
    clear_sb();
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_outputs", 64'({wr_en, wr_addr, wr_data, core_start, done, err}), 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // N=3, back-to-back bytes
    send_count(16'd3, 0, t);
    for (int k = 0; k < 3; k++) send_pair(prog3[k], 0, k, t);
    @(negedge clk);
    check("n3_ready_low", 64'(in_ready), 64'd0);
    halt_after("n3", t, 10);
    check_writes("n3");
    check("n3_start_len", 64'(start_count), 64'(START_CYC));
    check("n3_start_first", 64'(start_first), 64'(t + 2));

    // N=0 with a halt pulse during core_start that must be ignored
    do_reset();
    send_count(16'd0, 0, t);
    wait_until(t + 2);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    wait_until(t + 2 + START_CYC);
    check("n0_halt_ignored", 64'(done), 64'd0);
    halt_after("n0", t, 0);
    check_writes("n0");
    check("n0_start_len", 64'(start_count), 64'(START_CYC));
    check("n0_start_first", 64'(start_first), 64'(t + 2));

    // N=4 with random source gaps
    do_reset();
    send_count(16'd4, $urandom_range(0, 3), t);
    for (int k = 0; k < 4; k++) send_pair(prog4[k], $urandom_range(0, 3), k, t);
    @(negedge clk);
    check("gap_ready_low", 64'(in_ready), 64'd0);
    halt_after("gap", t, 3);
    check_writes("gap");
    check("gap_start_first", 64'(start_first), 64'(t + 2));

    // oversize count
    do_reset();
    send_count(16'd1025, 0, t);
    @(negedge clk);
    check("big_err", 64'(err), 64'd1);
    check("big_ready_low", 64'(in_ready), 64'd0);
    repeat (10) @(negedge clk);
    check_writes("big");
    check("big_no_start", 64'(start_count), 64'd0);
    check("big_err_sticky", 64'({err, done}), 64'b10);

    // reserved bits set in an instruction high byte
    do_reset();
    send_count(16'd2, 0, t);
    send_pair(9'h012, 0, 0, t);
    send_byte(8'h34, 0, t);
    send_byte(8'h03, 0, t);
    @(negedge clk);
    check("resv_err", 64'(err), 64'd1);
    check("resv_ready_low", 64'(in_ready), 64'd0);
    repeat (6) @(negedge clk);
    check_writes("resv");
    check("resv_no_start", 64'(start_count), 64'd0);

    // reset mid-load after 2 of 5, then a fresh N=1 stream
    do_reset();
    send_count(16'd5, 0, t);
    send_pair(9'h111, 0, 0, t);
    send_pair(9'h022, 0, 1, t);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_outputs", 64'({wr_en, wr_addr, wr_data, core_start, done, err}), 64'd0);
    check("mid_rst_cycles", 64'(cycles), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_ready", 64'(in_ready), 64'd1);
    check_writes("mid");
    clear_sb();
    send_count(16'd1, 0, t);
    send_pair(9'h0CD, 0, 0, t);
    halt_after("fresh", t, 1);
    check_writes("fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that writes the core's instruction memory: it accepts a byte stream over a valid/ready handshake, assembles 9-bit instructions, and writes them through the instruction-memory write port. It then pulses the core's start, waits for the core's halt, and reports completion and cycle count. It sits between the bench or host byte source and the processor top level, and is the write side of the instruction fetch path.

## Interface
- ADDR_W, 16: instruction address width, matching the PC width.
- INSTR_W, 9: instruction width.
- DEPTH, 1024: instruction memory capacity in words; larger counts are rejected.
- START_CYC, 2: number of cycles core_start is held high.
- CLK  in  1  clock; posedge only.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-source valid.
- in_data  in  8  byte payload.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  INSTR_W  write data.
- core_start  out  1  drives the core's start/init input.
- core_halt  in  1  core's halt flag.
- done  out  1  run complete; sticky until reset.
- err  out  1  malformed stream; sticky until reset.
- cycles  out  32  core run cycle count.

## Operation
- Stream format:
  - Count low byte, then count high byte (16-bit count N).
  - Then N instruction pairs: low byte = instr[7:0], high byte = {7'b0, instr[8]}.
- A byte is accepted only when in_valid and in_ready are both high.
- in_ready is a decode of the registered state: high in S_LEN_LO, S_LEN_HI, S_INS_LO and S_INS_HI, low in every other state.
- FSM states and transitions:
  - S_LEN_LO → S_LEN_HI on accept.
  - S_LEN_HI on accept:
    - N > DEPTH → S_ERR.
    - N == 0 → S_START.
    - Otherwise → S_INS_LO.
  - S_INS_LO → S_INS_HI on accept.
  - S_INS_HI on accept:
    - High byte bits[7:1] nonzero → S_ERR, no write.
    - Otherwise → issue a write; go to S_START if this was pair N, else S_INS_LO.
  - S_START: core_start high for START_CYC cycles, then → S_RUN.
  - S_RUN: → S_DONE on core_halt.
  - S_DONE and S_ERR are terminal until reset.
- Write address starts at 0 and increments by 1 after each write; pair k is written to address k.
- Arithmetic: the 16-bit count compares unsigned against DEPTH. The address counter never wraps because N ≤ DEPTH.
- core_halt is ignored outside S_RUN, including while core_start is high.
- cycles:
  - Cleared on reset.
  - Increments every S_RUN cycle in which core_halt is 0.
  - Saturates at 32'hFFFF_FFFF.
  - Frozen in S_DONE.
- Reset mid-load or mid-run aborts immediately: no further write, and core_start drops on the next edge.
- The core's own memory contents are not cleared by this block.

## Timing
- Reset values: in_ready 0 during the reset cycle and 1 after it (state S_LEN_LO); wr_en 0, wr_addr 0, wr_data 0, core_start 0, done 0, err 0, cycles 0.
- Write latency:
  - High byte accepted at cycle t → wr_en high for exactly cycle t+1, with the matching wr_addr and wr_data.
  - wr_addr and wr_data are stable while wr_en is high.
- Back-to-back bytes every cycle are supported with no stalls during loading. The next low byte may be accepted in the same cycle as the previous write.
- Start timing:
  - The last high byte (or the count high byte when N == 0) accepted at cycle t → core_start high for cycles t+2 .. t+1+START_CYC.
  - S_RUN begins at t+2+START_CYC.
  - in_ready is 0 from t+1 onward.
- Halt timing:
  - core_halt sampled high in S_RUN at cycle h → done high from h+1.
  - cycles equals the number of prior S_RUN cycles, so a halt in the first S_RUN cycle gives cycles = 0.
- err is high from the cycle after the offending byte is accepted.

## Structure
- Shared package loader_pkg:
  - The state enum (S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_START, S_RUN, S_DONE, S_ERR).
  - The high-byte reserved-bit mask constant.
- No sub-module: one FSM plus the address, start-width and cycle counters in one module.
- The processor top level instantiates inst_loader and ties core_start to the core start input and core_halt to the core halt output.

## Test plan
- Load N=3 of 9'h1A5, 9'h0FF, 9'h100 at one byte per cycle → writes to addresses 0, 1, 2 with those values one cycle after each high byte; core_start high for 2 cycles; halt asserted 10 cycles into S_RUN → done=1, cycles=10.
- N=0 → no wr_en; core_start two cycles after the count high byte is accepted; immediate halt → cycles=0.
- Random in_valid gaps with N=4 → identical write sequence; no byte lost or duplicated; in_ready=0 after the last byte.
- N=1025 with DEPTH=1024 → err=1, no wr_en, core_start never asserted, in_ready=0.
- Instruction high byte 8'h03 → err=1, no write for that pair.
- Reset asserted mid-load after 2 of 5 instructions → all outputs return to their reset values next cycle; a fresh N=1 stream then writes address 0.
